// File: rtl/gpio_axis_packer_pkg.sv
// Shared definitions for the GPIO-to-AXIS packer.
// The GPIO word carries a toggle bit in its MSB, a flush bit just below it,
// and the payload in the low WORD_W bits.
package gpio_axis_packer_pkg;

  localparam int GPIO_BUS_WIDTH = 32;

  // Control bit positions expressed relative to the GPIO bus width so
  // that a non-default GPIO_W keeps the same layout.
  function automatic int toggle_bit(input int gpio_w);
    return gpio_w - 1;
  endfunction

  function automatic int flush_bit(input int gpio_w);
    return gpio_w - 2;
  endfunction

  localparam int GPIO_TOGGLE_BIT = GPIO_BUS_WIDTH - 1;
  localparam int GPIO_FLUSH_BIT  = GPIO_BUS_WIDTH - 2;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } pack_state_t;

endpackage

// File: rtl/gpio_axis_packer_toggle_detect.sv
// gpio_toggle_detect: registers the raw GPIO word once and turns each change
// of its toggle bit into a single-cycle word strobe.
//   clk          in   clock
//   rst          in   synchronous active-low reset
//   gpio_in      in   raw GPIO word
//   word_strobe  out  one cycle per toggle change (after arming)
//   payload      out  registered payload bits of the word
//   flush        out  registered flush bit of the word
module gpio_toggle_detect
  import gpio_axis_packer_pkg::*;
#(
  parameter int GPIO_W = GPIO_BUS_WIDTH,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              word_strobe,
  output logic [WORD_W-1:0] payload,
  output logic              flush
);

  localparam int TOG_BIT = toggle_bit(GPIO_W);
  localparam int FLS_BIT = flush_bit(GPIO_W);

  logic tog_q;
  logic armed;
  logic tog_prev;

  // The input register is deliberately not reset: it must hold the live
  // toggle level across reset so the detector arms on the current level
  // and reports no spurious word when reset is released.
  always_ff @(posedge clk) begin
    tog_q   <= gpio_in[TOG_BIT];
    flush   <= gpio_in[FLS_BIT];
    payload <= gpio_in[WORD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      armed    <= 1'b0;
      tog_prev <= 1'b0;
    end else begin
      armed    <= 1'b1;
      tog_prev <= tog_q;
    end
  end

  assign word_strobe = armed && (tog_q != tog_prev);

  // Bits between the payload and the control bits carry nothing.
  generate
    if (GPIO_W - 2 > WORD_W) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^gpio_in[GPIO_W-3:WORD_W];
    end
  endgenerate

endmodule

// File: rtl/gpio_axis_packer.sv
// gpio_axis_packer: packs toggle-marked GPIO words into BUS_W-wide AXIS beats.
//   axis_clk       in   clock
//   rst            in   synchronous active-low reset
//   gpio_in        in   [GPIO_W-1]=toggle, [GPIO_W-2]=flush, [WORD_W-1:0]=payload
//   clear_stats    in   pulse: zero counters and overflow
//   m_axis_tdata   out  packed beat, lane 0 in the LSBs
//   m_axis_tvalid  out  beat valid
//   m_axis_tready  in   downstream ready
//   m_axis_tlast   out  beat was closed by a flush word
//   overflow       out  sticky: a word was dropped
//   word_count     out  words accepted (wraps)
//   beat_count     out  beats handed off (wraps)
//
// state | meaning
// FILL  | accumulator accepting words
// STALL | accumulator holds a complete beat, waiting for the output register
module gpio_axis_packer
  import gpio_axis_packer_pkg::*;
#(
  parameter int GPIO_W = GPIO_BUS_WIDTH,
  parameter int WORD_W = 16,
  parameter int BUS_W  = 256
) (
  input  logic              axis_clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic              clear_stats,
  output logic [BUS_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              overflow,
  output logic [31:0]       word_count,
  output logic [31:0]       beat_count
);

  localparam int LANES  = BUS_W / WORD_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic              word_strobe;
  logic [WORD_W-1:0] payload;
  logic              flush;

  gpio_toggle_detect #(
    .GPIO_W (GPIO_W),
    .WORD_W (WORD_W)
  ) u_detect (
    .clk         (axis_clk),
    .rst         (rst),
    .gpio_in     (gpio_in),
    .word_strobe (word_strobe),
    .payload     (payload),
    .flush       (flush)
  );

  pack_state_t       state, state_next;
  logic [BUS_W-1:0]  acc, acc_next;
  logic              acc_last, acc_last_next;
  logic [LANE_W-1:0] lane, lane_next;

  logic out_free;
  logic handoff;
  logic out_load;
  logic word_accept;
  logic word_drop;
  logic complete;

  assign out_free    = !m_axis_tvalid || m_axis_tready;
  assign handoff     = m_axis_tvalid && m_axis_tready;
  assign out_load    = (state == STALL) && out_free;
  // A word can enter the same cycle the completed beat moves out, which
  // keeps a continuous word stream from losing anything at beat boundaries.
  assign word_accept = word_strobe && ((state == FILL) || out_load);
  assign word_drop   = word_strobe && !word_accept;
  assign complete    = word_accept && (flush || (lane == LANE_W'(LANES - 1)));

  always_ff @(posedge axis_clk) begin
    if (!rst) begin
      state    <= FILL;
      acc      <= '0;
      acc_last <= 1'b0;
      lane     <= '0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      acc_last <= acc_last_next;
      lane     <= lane_next;
    end
  end

  always_comb begin
    state_next    = state;
    acc_next      = acc;
    acc_last_next = acc_last;
    lane_next     = lane;

    // Emptying the accumulator zeroes it so a short (flushed) beat
    // carries zeros in its unfilled lanes.
    if (out_load) begin
      acc_next      = '0;
      acc_last_next = 1'b0;
      state_next    = FILL;
    end

    if (word_accept) begin
      acc_next[int'(lane)*WORD_W +: WORD_W] = payload;
      lane_next = lane + 1'b1;
    end

    if (complete) begin
      acc_last_next = flush;
      lane_next     = '0;
      state_next    = STALL;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (out_load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= acc;
      m_axis_tlast  <= acc_last;
    end else if (handoff) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!rst || clear_stats) begin
      word_count <= '0;
      beat_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (word_accept) word_count <= word_count + 32'd1;
      if (handoff)     beat_count <= beat_count + 32'd1;
      if (word_drop)   overflow   <= 1'b1;
    end
  end

endmodule
